pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 18 +
 rtl/pc_sequencer_if.sv | 32 +++
 rtl/pc_sequencer_ret_stack.sv | 66 ++++++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer:
// FSM state encoding, sticky error bit positions and default sizing.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam int D_DEFAULT         = 12;
  localparam int RAS_DEPTH_DEFAULT = 4;

  // Positions inside the 2-bit err vector.
  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/bus bundle between the instruction pipeline (master) and the
// sequencer (slave): requests and PC feedback in, PC load controls out.
interface pc_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int D = D_DEFAULT
);
  logic         start;
  logic         halt;
  logic         stall;
  logic         branch_taken;
  logic         call;
  logic         ret;
  logic [D-1:0] branch_target;
  logic [D-1:0] prog_ctr;
  logic         pc_reset;
  logic         absjump_en;
  logic [D-1:0] target;
  logic         busy;
  logic         done;
  logic [1:0]   err;

  modport master (
    output start, halt, stall, branch_taken, call, ret, branch_target, prog_ctr,
    input  pc_reset, absjump_en, target, busy, done, err
  );

  modport slave (
    input  start, halt, stall, branch_taken, call, ret, branch_target, prog_ctr,
    output pc_reset, absjump_en, target, busy, done, err
  );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack. Entries above the depth counter are never exposed,
// so only the counter needs resetting to discard all contents.
module ret_stack #(
  parameter int D     = 12,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  logic [D-1:0]  entries_r [DEPTH];
  logic [CW-1:0] count_r;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] top_idx_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign wr_idx_s  = IW'(count_r);
  assign top_idx_s = IW'(count_r - CW'(1));
  assign do_push_s = push && !full && !clear;
  assign do_pop_s  = pop && !empty && !clear;

  // Top-of-stack view, masked to zero when nothing is stored.
  always_comb begin
    top = {D{1'b0}};
    if (empty) begin
      top = {D{1'b0}};
    end else begin
      top = entries_r[top_idx_s];
    end
  end

  // Depth counter; push takes precedence but the caller never asserts both.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= CW'(0);
    end else if (clear) begin
      count_r <= CW'(0);
    end else if (do_push_s) begin
      count_r <= count_r + CW'(1);
    end else if (do_pop_s) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    if (reset && do_push_s) begin
      entries_r[wr_idx_s] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: IDLE/RUN/DONE control deciding each cycle whether the PC
// increments or loads an absolute target, with a call/return stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D         = D_DEFAULT,
  parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RUN  = ST_RUN;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [1:0]   err_r;
  logic [1:0]   err_set_s;
  logic         abs_s;
  logic [D-1:0] target_s;
  logic         push_s;
  logic         pop_s;
  logic         clear_s;
  logic [D-1:0] stk_top_s;
  logic         stk_full_s;
  logic         stk_empty_s;

  assign clear_s = (state_r == S_DONE) && bus.start;

  ret_stack #(.D(D), .DEPTH(RAS_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (bus.prog_ctr + D'(1)),
    .top       (stk_top_s),
    .full      (stk_full_s),
    .empty     (stk_empty_s)
  );

  // Next-state and PC-load decision; RUN requests resolved by fixed priority.
  always_comb begin
    state_nxt_s = state_r;
    abs_s       = 1'b0;
    target_s    = {D{1'b0}};
    push_s      = 1'b0;
    pop_s       = 1'b0;
    err_set_s   = 2'b00;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.halt) begin
          abs_s       = 1'b1;
          target_s    = bus.prog_ctr;
          state_nxt_s = S_DONE;
        end else if (bus.stall) begin
          abs_s    = 1'b1;
          target_s = bus.prog_ctr;
        end else if (bus.ret) begin
          abs_s = 1'b1;
          if (stk_empty_s) begin
            target_s           = bus.prog_ctr;
            err_set_s[ERR_UNF] = 1'b1;
            state_nxt_s        = S_DONE;
          end else begin
            target_s = stk_top_s;
            pop_s    = 1'b1;
          end
        end else if (bus.call) begin
          abs_s = 1'b1;
          if (stk_full_s) begin
            target_s           = bus.prog_ctr;
            err_set_s[ERR_OVF] = 1'b1;
            state_nxt_s        = S_DONE;
          end else begin
            target_s = bus.branch_target;
            push_s   = 1'b1;
          end
        end else if (bus.branch_taken) begin
          abs_s    = 1'b1;
          target_s = bus.branch_target;
        end else begin
          abs_s    = 1'b0;
          target_s = {D{1'b0}};
        end
      end
      S_DONE: begin
        abs_s    = 1'b1;
        target_s = bus.prog_ctr;
        if (bus.start) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sticky error flags, cleared only by reset or acknowledging DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_r <= 2'b00;
    end else if (clear_s) begin
      err_r <= 2'b00;
    end else begin
      err_r <= err_r | err_set_s;
    end
  end

  assign bus.pc_reset   = (state_r == S_IDLE);
  assign bus.busy       = (state_r == S_RUN);
  assign bus.done       = (state_r == S_DONE);
  assign bus.err        = err_r;
  assign bus.absjump_en = abs_s;
  assign bus.target     = target_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a simple PC register model closing
// the loop; expected values are hand-computed constants.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int D = 12;

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  pc_sequencer_if #(.D(D)) bus ();

  pc_sequencer #(.D(D), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register driven by the sequencer's load controls.
  always_ff @(posedge clk) begin
    if (bus.pc_reset) begin
      bus.prog_ctr <= 12'h000;
    end else if (bus.absjump_en) begin
      bus.prog_ctr <= bus.target;
    end else begin
      bus.prog_ctr <= bus.prog_ctr + 12'h001;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared = n_compared + 1;
    if (got !== exp) begin
      n_mismatched = n_mismatched + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    bus.start         = 1'b0;
    bus.halt          = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.call          = 1'b0;
    bus.ret           = 1'b0;
    bus.branch_target = 12'h000;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    clr_req();
    reset = 1'b0;

    // Reset for two cycles.
    tick(); tick();
    check_val("rst_pc_reset", 32'(bus.pc_reset), 32'd1);
    check_val("rst_abs", 32'(bus.absjump_en), 32'd0);
    check_val("rst_target", 32'(bus.target), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_err", 32'(bus.err), 32'd0);

    // Start pulse, then free-running sequential PC.
    reset = 1'b1;
    bus.start = 1'b1;
    #1;
    check_val("idle_pc_reset", 32'(bus.pc_reset), 32'd1);
    tick();
    bus.start = 1'b0;
    #1;
    check_val("run_busy", 32'(bus.busy), 32'd1);
    check_val("run_pc_reset", 32'(bus.pc_reset), 32'd0);
    check_val("seq_abs", 32'(bus.absjump_en), 32'd0);
    check_val("seq_pc0", 32'(bus.prog_ctr), 32'h000);
    tick(); check_val("seq_pc1", 32'(bus.prog_ctr), 32'h001);
    tick(); check_val("seq_pc2", 32'(bus.prog_ctr), 32'h002);
    tick(); check_val("seq_pc3", 32'(bus.prog_ctr), 32'h003);
    tick(); tick();
    check_val("seq_pc5", 32'(bus.prog_ctr), 32'h005);

    // Stall three cycles at 0x005.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("stall_abs", 32'(bus.absjump_en), 32'd1);
      check_val("stall_target", 32'(bus.target), 32'h005);
      tick();
    end
    bus.stall = 1'b0;
    check_val("stall_held_pc", 32'(bus.prog_ctr), 32'h005);
    tick();
    check_val("stall_resume_pc", 32'(bus.prog_ctr), 32'h006);

    // Branch to 0x010, call 0x200, then return to 0x011.
    bus.branch_taken = 1'b1;
    bus.branch_target = 12'h010;
    #1;
    check_val("br_target", 32'(bus.target), 32'h010);
    tick();
    bus.branch_taken = 1'b0;
    check_val("br_pc", 32'(bus.prog_ctr), 32'h010);
    bus.call = 1'b1;
    bus.branch_target = 12'h200;
    #1;
    check_val("call_abs", 32'(bus.absjump_en), 32'd1);
    check_val("call_target", 32'(bus.target), 32'h200);
    tick();
    bus.call = 1'b0;
    check_val("call_pc", 32'(bus.prog_ctr), 32'h200);
    tick();
    check_val("sub_pc", 32'(bus.prog_ctr), 32'h201);
    bus.ret = 1'b1;
    bus.call = 1'b1;
    #1;
    check_val("ret_over_call_target", 32'(bus.target), 32'h011);
    tick();
    bus.ret = 1'b0;
    bus.call = 1'b0;
    check_val("ret_pc", 32'(bus.prog_ctr), 32'h011);
    check_val("ret_err", 32'(bus.err), 32'd0);

    // Halt beats stall; DONE freezes the PC.
    bus.halt = 1'b1;
    bus.stall = 1'b1;
    #1;
    check_val("halt_target", 32'(bus.target), 32'h011);
    tick();
    clr_req();
    bus.branch_taken = 1'b1;
    bus.branch_target = 12'h3aa;
    #1;
    check_val("halt_done", 32'(bus.done), 32'd1);
    check_val("halt_busy", 32'(bus.busy), 32'd0);
    check_val("done_abs", 32'(bus.absjump_en), 32'd1);
    check_val("done_target", 32'(bus.target), 32'h011);
    tick();
    check_val("done_frozen_pc", 32'(bus.prog_ctr), 32'h011);
    clr_req();
    bus.start = 1'b1;
    tick();
    check_val("ack_idle", 32'(bus.pc_reset), 32'd1);

    // Five nested calls into a four-deep stack.
    tick();
    bus.start = 1'b0;
    #1;
    check_val("ovf_run_pc", 32'(bus.prog_ctr), 32'h000);
    bus.call = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.branch_target = 12'h100 + 12'(i * 16);
      tick();
    end
    bus.branch_target = 12'h7ff;
    #1;
    check_val("ovf_pc_before", 32'(bus.prog_ctr), 32'h130);
    check_val("ovf_target", 32'(bus.target), 32'h130);
    tick();
    bus.call = 1'b0;
    check_val("ovf_err", 32'(bus.err), 32'b01);
    check_val("ovf_done", 32'(bus.done), 32'd1);
    tick();
    check_val("ovf_frozen_pc", 32'(bus.prog_ctr), 32'h130);
    bus.start = 1'b1;
    tick();
    check_val("ovf_ack_err", 32'(bus.err), 32'd0);
    check_val("ovf_ack_idle", 32'(bus.pc_reset), 32'd1);

    // Return with an empty stack (stack must have been cleared above).
    tick();
    bus.start = 1'b0;
    bus.ret = 1'b1;
    #1;
    check_val("unf_target", 32'(bus.target), 32'h000);
    check_val("unf_abs", 32'(bus.absjump_en), 32'd1);
    tick();
    bus.ret = 1'b0;
    check_val("unf_err", 32'(bus.err), 32'b10);
    check_val("unf_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    tick();
    tick();
    bus.start = 1'b0;

    // Reset mid-RUN with two entries stacked.
    bus.call = 1'b1;
    bus.branch_target = 12'h040;
    tick();
    bus.branch_target = 12'h080;
    tick();
    clr_req();
    check_val("mid_pc", 32'(bus.prog_ctr), 32'h080);
    reset = 1'b0;
    tick();
    check_val("mid_rst_pc_reset", 32'(bus.pc_reset), 32'd1);
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_val("mid_rst_done", 32'(bus.done), 32'd0);
    check_val("mid_rst_abs", 32'(bus.absjump_en), 32'd0);
    check_val("mid_rst_target", 32'(bus.target), 32'd0);
    check_val("mid_rst_err", 32'(bus.err), 32'd0);
    reset = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ret = 1'b1;
    #1;
    check_val("mid_rst_empty_target", 32'(bus.target), 32'h000);
    tick();
    bus.ret = 1'b0;
    check_val("mid_rst_unf_err", 32'(bus.err), 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
